mlp_result_reader: RTL
======================

# mlp_result_reader

Output-side companion to the `MLP` core. It watches the core's two 32-bit IEEE-754 single-precision outputs and waits until they stop changing, since the core has no done flag. It then snapshots them, computes the winning class (argmax), and streams the words out over a valid/ready interface. It sits between `MLP` and whatever collects results: a bench scoreboard, a UART, or a host FIFO.

## Interface
Parameters:
- `N_OUT`, 2, number of MLP output words
- `WIDTH`, 32, bits per output word (IEEE-754 single)
- `SETTLE_CYCLES`, 16, consecutive unchanged cycles that qualify outputs as final (≥2)

Ports:
- `CLK`  in  1  clock; one clock domain, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `mlp_out`  in  N_OUT*WIDTH  flattened core outputs; word i at `[i*WIDTH +: WIDTH]`
- `arm`  in  1  one-cycle pulse; begin watching for a new result
- `m_data`  out  WIDTH  streamed result word
- `m_valid`  out  1  `m_data` valid
- `m_ready`  in  1  sink accepts word
- `m_last`  out  1  high with the final word (index N_OUT-1)
- `class_idx`  out  $clog2(N_OUT) (min 1)  argmax index
- `class_valid`  out  1  `class_idx` valid
- `busy`  out  1  high in every state except IDLE and DONE

## Operation
The block is driven by a state machine with these states: IDLE, SETTLE, SCAN, SEND, DONE.

- **IDLE**
  - `arm` loads `prev <= mlp_out` and `cnt <= 0`, then moves to SETTLE.
- **SETTLE** (one compare per cycle)
  - If `mlp_out != prev`: `cnt <= 0`.
  - Otherwise: `cnt <= cnt + 1`.
  - `prev <= mlp_out` every cycle.
  - When `mlp_out == prev` and `cnt == SETTLE_CYCLES-2`: `snap <= mlp_out`, `i <= 0`, move to SCAN.
- **SCAN** (one element per cycle, N_OUT cycles)
  - Each element is mapped to an order key: `key(x) = x[WIDTH-1] ? ~x : x ^ (1<<(WIDTH-1))`, compared unsigned.
  - At `i == 0`: `best <= key(snap[0])`, `idx <= 0`.
  - At `i > 0`: replace best only if the new key is strictly greater. Ties keep the lower index.
  - `+0` and `-0` compare as different keys (`-0` < `+0`). NaNs are ordered by the same key; no special handling.
  - After `i == N_OUT-1`: `class_idx <= idx`, `i <= 0`, move to SEND.
- **SEND**
  - `m_valid = 1`, `m_data = snap[i]`, `m_last = (i == N_OUT-1)`.
  - On `m_valid & m_ready`: increment `i`.
  - On the last handshake: `class_valid <= 1`, move to DONE.
- **DONE**
  - Holds `class_idx` and `class_valid`.
  - `arm` clears `class_valid` and re-enters SETTLE, exactly as from IDLE.
- **`arm` in SETTLE, SCAN or SEND:** ignored.
- **`mlp_out` changing after the snapshot:** no effect until the next `arm`.
- **`cnt` width:** saturates at `SETTLE_CYCLES-1`; it never wraps.

## Timing
- **Reset** (synchronous, wins over everything including `arm`):
  - State goes to IDLE.
  - `m_valid`, `m_last`, `class_valid`, `busy`, `class_idx` and `m_data` all go to 0.
  - `cnt` and `i` go to 0.
  - Reset asserted mid-SEND drops `m_valid` on the next edge. A partially sent result is discarded.
- **Latency** with `mlp_out` constant and `arm` sampled at edge 0:
  - Snapshot at edge `SETTLE_CYCLES`.
  - SCAN occupies edges `SETTLE_CYCLES+1` .. `SETTLE_CYCLES+N_OUT`.
  - `m_valid` is high after edge `SETTLE_CYCLES+N_OUT`.
  - A change in `mlp_out` restarts the count: the snapshot occurs `SETTLE_CYCLES` edges after the last change.
- **Stream rules:**
  - `m_data` and `m_last` stay stable while `m_valid & !m_ready`.
  - `m_valid` never depends combinationally on `m_ready`.
  - With `m_ready` held high, words go out on consecutive cycles.
- **`class_valid`** rises on the edge that accepts the last word.
- **All outputs** are registered.

## Structure
- **Shared package `mlp_pkg`:**
  - State enum / localparams for the states.
  - `N_OUT` and `WIDTH` defaults, shared with `MLP`.
  - Float order-key function.
- **Sub-module `mlp_stability_detector`:**
  - Contains `prev`, `cnt` and the equal-compare.
  - Output `stable_pulse`.
- **FSM, scan and stream logic** stay in the top module.

## Test plan
1. **Basic argmax and order.** `mlp_out` = {`3F800000` (1.0), `40000000` (2.0)}, `arm`, `m_ready`=1 → `m_data` `3F800000` then `40000000`, `m_last` on the second word, `class_idx`=1, `class_valid`=1; `m_valid` rises after edge 18.
2. **Negative values.** {`BF800000` (-1.0), `C0000000` (-2.0)} → `class_idx`=0. {`80000000` (-0), `00000000` (+0)} → `class_idx`=1.
3. **Tie.** Both words `3F800000` → `class_idx`=0.
4. **Settling restart.** Word 1 toggles at cycles 5 and 12 after `arm`, final value `41200000` → snapshot holds `41200000`; `m_valid` rises after edge 12+16+2.
5. **Backpressure.** `m_ready` low for 5 cycles in SEND → `m_data`/`m_last` held, no word lost or duplicated.
6. **Reset mid-SEND, then re-arm.** Reset asserted during SEND → all outputs 0 next edge. A subsequent `arm` produces a full fresh transfer. `arm` while in SCAN is ignored.

Source files
------------

// File: rtl/mlp_pkg.sv
// mlp_pkg: shared MLP defaults, result-reader state enum and IEEE-754 order-key helper
package mlp_pkg;
  localparam int MLP_N_OUT = 2;
  localparam int MLP_WIDTH = 32;
  typedef enum logic [2:0] {IDLE, SETTLE, SCAN, SEND, DONE} state_t;
  function automatic logic [63:0] order_key(input logic [63:0] x, input int w);
    logic [63:0] msb;
    msb = 64'(1) << (w - 1);
    return (x & msb) != '0 ? ~x & ((msb << 1) - 64'(1)) : x ^ msb;
  endfunction
endpackage

// File: rtl/mlp_stability_detector.sv
// mlp_stability_detector: clk/reset; load restarts watch on din; en runs compare; stable_pulse (registered) flags din unchanged for SETTLE_CYCLES edges, stable_val holds that value
module mlp_stability_detector #(
  parameter int W = 64,
  parameter int SETTLE_CYCLES = 16,
  localparam int CW = $clog2(SETTLE_CYCLES)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic         stable_pulse,
  output logic [W-1:0] stable_val
);
  localparam logic [CW-1:0] CMAX = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CHIT = CW'(SETTLE_CYCLES - 2);
  logic [W-1:0] prev;
  logic [CW-1:0] cnt;
  logic eq;
  assign eq = din == prev;
  assign stable_val = prev;
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= '0;
      cnt <= '0;
      stable_pulse <= 1'b0;
    end else if (load) begin
      prev <= din;
      cnt <= '0;
      stable_pulse <= 1'b0;
    end else if (en) begin
      prev <= din;
      cnt <= !eq ? '0 : cnt == CMAX ? cnt : cnt + 1'b1;
      stable_pulse <= eq && cnt == CHIT;
    end else begin
      stable_pulse <= 1'b0;
    end
  end
endmodule

// File: rtl/mlp_result_reader.sv
// mlp_result_reader: CLK/reset; mlp_out watched after arm until stable, snapshotted, argmax to class_idx/class_valid, words streamed on m_data/m_valid/m_ready/m_last; busy outside IDLE/DONE
module mlp_result_reader
  import mlp_pkg::*;
#(
  parameter int N_OUT = MLP_N_OUT,
  parameter int WIDTH = MLP_WIDTH,
  parameter int SETTLE_CYCLES = 16,
  localparam int IW = N_OUT > 1 ? $clog2(N_OUT) : 1
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [N_OUT*WIDTH-1:0] mlp_out,
  input  logic                   arm,
  output logic [WIDTH-1:0]       m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [IW-1:0]          class_idx,
  output logic                   class_valid,
  output logic                   busy
);
  localparam logic [IW-1:0] LAST = IW'(N_OUT - 1);
  state_t state, state_n;
  logic [WIDTH-1:0] snap [N_OUT];
  logic [WIDTH-1:0] best, cur_key;
  logic [IW-1:0] i, idx, scan_idx;
  logic [N_OUT*WIDTH-1:0] stable_val;
  logic stable_pulse, load, win, fire;
  assign load = arm && (state == IDLE || state == DONE);
  assign fire = state == SEND && m_valid && m_ready;
  assign cur_key = WIDTH'(order_key(64'(snap[i]), WIDTH));
  assign win = i == '0 || cur_key > best;
  assign scan_idx = win ? i : idx;
  mlp_stability_detector #(.W(N_OUT*WIDTH), .SETTLE_CYCLES(SETTLE_CYCLES)) u_det (
    .clk(CLK),
    .reset(reset),
    .load(load),
    .en(state == SETTLE),
    .din(mlp_out),
    .stable_pulse(stable_pulse),
    .stable_val(stable_val)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = arm ? SETTLE : state;
      SETTLE:     state_n = stable_pulse ? SCAN : SETTLE;
      SCAN:       state_n = i == LAST ? SEND : SCAN;
      SEND:       state_n = fire && m_last ? DONE : SEND;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      i <= '0;
      idx <= '0;
      best <= '0;
      class_idx <= '0;
      class_valid <= 1'b0;
      m_valid <= 1'b0;
      m_last <= 1'b0;
      m_data <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      busy <= state_n != IDLE && state_n != DONE;
      if (load) class_valid <= 1'b0;
      if (state == SETTLE && stable_pulse) begin
        for (int k = 0; k < N_OUT; k++) snap[k] <= stable_val[k*WIDTH +: WIDTH];
        i <= '0;
      end
      if (state == SCAN) begin
        best <= win ? cur_key : best;
        idx <= scan_idx;
        i <= i == LAST ? '0 : i + 1'b1;
        if (i == LAST) begin
          class_idx <= scan_idx;
          m_valid <= 1'b1;
          m_data <= snap[0];
          m_last <= LAST == '0;
        end
      end
      if (fire) begin
        if (m_last) begin
          m_valid <= 1'b0;
          m_last <= 1'b0;
          class_valid <= 1'b1;
          i <= '0;
        end else begin
          i <= i + 1'b1;
          m_data <= snap[i + 1'b1];
          m_last <= i + 1'b1 == LAST;
        end
      end
    end
  end
endmodule
